ir_sense_seq: RTL
=================

# ir_sense_seq

Sequencer for the IR wall-sensing front end of the maze runner. It periodically enables the IR emitters, waits for them to settle, and requests left then right conversions from the shared A2D interface. It captures the results, derives the wall-open flags with hysteresis, and presents registered `lft_IR`, `rght_IR`, `lft_opn`, `rght_opn` and `en_fusion` to the heading-fusion math. It owns every A2D request that sensing makes.

## Interface
- `SETTLE_CLKS`, 4096: clocks emitters are on before the first lit conversion.
- `PERIOD_CLKS`, 65536: minimum clocks between frame starts.
- `TMO_CLKS`, 1024: max clocks from `strt_cnv` to `cnv_cmplt`.
- `OPN_THRESH`, 12'h200: open threshold on the corrected reading.
- `HYST`, 12'h040: hysteresis half-band.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: sensing enable.
- `strt_cnv` out 1: one-cycle A2D conversion request.
- `chnnl` out 3: A2D channel; stable from `strt_cnv` until `cnv_cmplt`.
- `cnv_cmplt` in 1: one-cycle A2D done pulse.
- `res` in 12: A2D result, valid with `cnv_cmplt`.
- `IR_en` out 1: emitter drive.
- `lft_IR`, `rght_IR` out 12 each: corrected readings.
- `lft_opn`, `rght_opn` out 1 each: wall-open flags.
- `en_fusion` out 1: readings trustworthy.
- `frm_vld` out 1: one-cycle pulse when a frame's outputs update.
- `tmo_err` out 1: sticky conversion-timeout flag; cleared only by reset.

## Operation
- States: IDLE, AMB_L, AMB_R, SETTLE, LIT_L, LIT_R, UPDATE, DRAIN.
- IDLE:
  - Leaves when `en`=1 and the period counter has reached `PERIOD_CLKS-1`.
  - The period counter is free-running, saturates at `PERIOD_CLKS-1`, and clears on each frame start.
  - A frame longer than the period therefore starts the next frame in the cycle after UPDATE.
- Conversion states (AMB_*, LIT_*):
  - On entry, pulse `strt_cnv` once and drive `chnnl` (left=`CH_LFT`, right=`CH_RGHT`).
  - Wait for `cnv_cmplt`, then capture `res` into the slot for that state.
- Sequence, `IR_AMBIENT_CANCEL_EN` defined: IDLE→AMB_L→AMB_R→SETTLE→LIT_L→LIT_R→UPDATE→IDLE.
- Sequence, macro undefined: IDLE→SETTLE→LIT_L→LIT_R→UPDATE→IDLE.
- `IR_en`:
  - 1 in SETTLE, LIT_L and LIT_R.
  - Rises on SETTLE entry and falls on UPDATE entry.
  - 0 in every other state.
- SETTLE lasts exactly `SETTLE_CLKS` cycles.
- UPDATE lasts one cycle and:
  - Registers corrected readings into `lft_IR`/`rght_IR`.
  - Updates the open flags.
  - Pulses `frm_vld`.
  - Sets `en_fusion`=1.
- Correction: corrected = lit − ambient, 13-bit signed intermediate, saturated to 0 if negative, 12-bit result. Without the macro, corrected = lit.
- Open flag per side:
  - Set when corrected < `OPN_THRESH-HYST`.
  - Cleared when corrected > `OPN_THRESH+HYST`.
  - Otherwise holds.
  - Compare unsigned, on 13-bit values to avoid wrap.
- Abort on `en` low:
  - In SETTLE: go IDLE immediately; `IR_en`=0.
  - In a conversion state: go DRAIN, then wait for `cnv_cmplt` (or timeout) before IDLE; the result is discarded.
  - Outputs hold their last values, and `en_fusion` drops to 0 the cycle after `en` is seen low.
- Timeout:
  - If `cnv_cmplt` has not arrived `TMO_CLKS` cycles after `strt_cnv`, set `tmo_err` and go IDLE.
  - `IR_en`=0, outputs hold, `en_fusion`=0.
- `cnv_cmplt` arriving in IDLE, SETTLE or UPDATE is ignored.
- `en_fusion` next rises at the following successful UPDATE.

## Timing
- Reset values:
  - State IDLE, period counter `PERIOD_CLKS-1` (first frame starts the cycle after `en`).
  - `strt_cnv`=0, `chnnl`=`CH_LFT`, `IR_en`=0.
  - `lft_IR`=`rght_IR`=0, `lft_opn`=`rght_opn`=1.
  - `en_fusion`=0, `frm_vld`=0, `tmo_err`=0.
- All outputs are registered.
- `strt_cnv` is asserted the cycle after conversion-state entry.
- A `cnv_cmplt` at cycle t causes the next state at t+1.
- Outputs change the cycle after UPDATE, coincident with the `frm_vld` pulse.
- Frame latency with A2D latency L:
  - Macro defined: 1+2(L+1)+`SETTLE_CLKS`+2(L+1)+1 cycles.
  - Macro undefined: 1+`SETTLE_CLKS`+2(L+1)+1 cycles.

## Configuration
- Macro `IR_AMBIENT_CANCEL_EN`.
- Defined: two emitter-off ambient conversions precede each lit pair, and the result is subtracted with saturation.
- Undefined: AMB states are not compiled, ambient registers are absent, and corrected = lit.

## Structure
- Package `ir_pkg` holds:
  - The state enum `ir_state_t`.
  - Channel constants `CH_LFT`=3'd0 and `CH_RGHT`=3'd4.
  - A shared `NOM_IR`=12'h900 constant.
- Natural sub-module `ir_opn_hyst`:
  - One instance per side.
  - Registers the flag and applies the threshold/hysteresis rule, enabled by the UPDATE strobe.

## Test plan
- Reset, `en`=1, A2D model with L=10, lit left=12'h700, lit right=12'h100, ambient 12'h050 → first `frm_vld` with `lft_IR`=12'h6B0, `rght_IR`=12'h0B0, `lft_opn`=0, `rght_opn`=1, `en_fusion`=1; `IR_en` high for exactly `SETTLE_CLKS`+2(L+1) cycles.
- Ambient 12'h300 > lit 12'h100 → corrected 0, open=1 (saturation; macro defined).
- Left corrected sequence 12'h150, 12'h1E0, 12'h250, 12'h1E0, 12'h1B0 (threshold 12'h200 ± 12'h040) → `lft_opn` 1,1,0,0,1.
- `cnv_cmplt` withheld in LIT_L → `tmo_err`=1 at `TMO_CLKS`+1 cycles after `strt_cnv`; `IR_en`=0; next frame starts at the following period tick.
- `en` dropped during LIT_R with the A2D pending → DRAIN until `cnv_cmplt`, no `frm_vld`, outputs unchanged, `en_fusion`=0.
- `PERIOD_CLKS`=16, shorter than the frame → frames back-to-back, one idle cycle between UPDATE and the next `strt_cnv` frame start.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding, A2D channel map and helpers for the IR wall-sensing sequencer.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AMB_L,
        AMB_R,
        SETTLE,
        LIT_L,
        LIT_R,
        UPDATE,
        DRAIN
    } ir_state_t;

    localparam logic [2:0] CH_LFT = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [11:0] NOM_IR = 12'h900;

    // Lit minus ambient, clamped at zero when ambient exceeds the lit reading.
    function automatic logic [11:0] ir_sub_sat(input logic [11:0] lit, input logic [11:0] amb);
        logic [12:0] d;
        d = {1'b0, lit} - {1'b0, amb};
        return d[12] ? 12'h000 : d[11:0];
    endfunction

endpackage

// File: rtl/ir_sense_seq_opn_hyst.sv
// ir_opn_hyst: registered wall-open flag with threshold hysteresis, updated on the frame strobe.
module ir_opn_hyst #(
    parameter logic [11:0] OPN_THRESH = 12'h200,
    parameter logic [11:0] HYST = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd,
    input  logic [11:0] val,
    output logic        opn
);

    // 13-bit band edges so a large hysteresis cannot wrap the comparison.
    localparam logic [12:0] LO = {1'b0, OPN_THRESH} - {1'b0, HYST};
    localparam logic [12:0] HI = {1'b0, OPN_THRESH} + {1'b0, HYST};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            opn <= 1'b1;
        else if (upd)
            opn <= ({1'b0, val} < LO) ? 1'b1 : ({1'b0, val} > HI) ? 1'b0 : opn;

endmodule

// File: rtl/ir_sense_seq.sv
// ir_sense_seq: periodic IR emitter/A2D sequencer producing corrected wall readings and open flags.
// Define IR_AMBIENT_CANCEL_EN to add emitter-off ambient conversions that are subtracted from the lit pair.
module ir_sense_seq
    import ir_pkg::*;
#(
    parameter int unsigned SETTLE_CLKS = 4096,
    parameter int unsigned PERIOD_CLKS = 65536,
    parameter int unsigned TMO_CLKS = 1024,
    parameter logic [11:0] OPN_THRESH = 12'h200,
    parameter logic [11:0] HYST = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        IR_en,
    output logic [11:0] lft_IR,
    output logic [11:0] rght_IR,
    output logic        lft_opn,
    output logic        rght_opn,
    output logic        en_fusion,
    output logic        frm_vld,
    output logic        tmo_err
);

    localparam logic [31:0] SET_END = 32'(SETTLE_CLKS - 1);
    localparam logic [31:0] PER_END = 32'(PERIOD_CLKS - 1);
    localparam logic [31:0] TMO_END = 32'(TMO_CLKS);
`ifdef IR_AMBIENT_CANCEL_EN
    localparam ir_state_t FIRST = AMB_L;
`else
    localparam ir_state_t FIRST = SETTLE;
`endif

    ir_state_t   state, nxt, adv;
    logic [31:0] cnt, pcnt;
    logic [11:0] lit_l, lit_r, cor_l, cor_r;
    logic        is_cnv, tmo, start, enter_cnv;

    assign is_cnv    = state inside {AMB_L, AMB_R, LIT_L, LIT_R};
    assign tmo       = (is_cnv || state == DRAIN) && !cnv_cmplt && cnt == TMO_END;
    assign start     = state == IDLE && en && pcnt == PER_END;
    assign enter_cnv = nxt != state && nxt inside {AMB_L, AMB_R, LIT_L, LIT_R};

`ifdef IR_AMBIENT_CANCEL_EN
    logic [11:0] amb_l, amb_r;
    assign cor_l = ir_sub_sat(lit_l, amb_l);
    assign cor_r = ir_sub_sat(lit_r, amb_r);
`else
    assign cor_l = lit_l;
    assign cor_r = lit_r;
`endif

    always_comb begin
        adv = state;
        nxt = state;
        case (state)
`ifdef IR_AMBIENT_CANCEL_EN
            AMB_L: adv = AMB_R;
            AMB_R: adv = SETTLE;
`endif
            LIT_L: adv = LIT_R;
            LIT_R: adv = UPDATE;
            default: adv = state;
        endcase
        case (state)
            IDLE:    nxt = start ? FIRST : IDLE;
            SETTLE:  nxt = !en ? IDLE : (cnt == SET_END) ? LIT_L : SETTLE;
            UPDATE:  nxt = IDLE;
            DRAIN:   nxt = (cnv_cmplt || tmo) ? IDLE : DRAIN;
            // A completion coinciding with the abort leaves nothing in flight, so skip DRAIN.
            default: nxt = tmo ? IDLE : !en ? (cnv_cmplt ? IDLE : DRAIN) : cnv_cmplt ? adv : state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pcnt      <= PER_END;
            strt_cnv  <= 1'b0;
            chnnl     <= CH_LFT;
            IR_en     <= 1'b0;
            frm_vld   <= 1'b0;
            en_fusion <= 1'b0;
            tmo_err   <= 1'b0;
            lft_IR    <= '0;
            rght_IR   <= '0;
            lit_l     <= '0;
            lit_r     <= '0;
`ifdef IR_AMBIENT_CANCEL_EN
            amb_l     <= '0;
            amb_r     <= '0;
`endif
        end else begin
            state     <= nxt;
            // DRAIN keeps counting from the original strt_cnv so its timeout stays bounded.
            cnt       <= (state == IDLE || (nxt != state && nxt != DRAIN)) ? '0 : cnt + 32'd1;
            pcnt      <= start ? '0 : (pcnt == PER_END) ? pcnt : pcnt + 32'd1;
            strt_cnv  <= enter_cnv;
            chnnl     <= enter_cnv ? ((nxt inside {AMB_L, LIT_L}) ? CH_LFT : CH_RGHT) : chnnl;
            IR_en     <= nxt inside {SETTLE, LIT_L, LIT_R};
            frm_vld   <= state == UPDATE;
            en_fusion <= en && !tmo && (state == UPDATE || en_fusion);
            tmo_err   <= tmo_err || tmo;
            if (state == UPDATE) begin
                lft_IR  <= cor_l;
                rght_IR <= cor_r;
            end
            if (cnv_cmplt && en) begin
                if (state == LIT_L) lit_l <= res;
                if (state == LIT_R) lit_r <= res;
`ifdef IR_AMBIENT_CANCEL_EN
                if (state == AMB_L) amb_l <= res;
                if (state == AMB_R) amb_r <= res;
`endif
            end
        end

    ir_opn_hyst #(.OPN_THRESH(OPN_THRESH), .HYST(HYST)) u_lft (
        .clk(clk), .rst_n(rst_n), .upd(state == UPDATE), .val(cor_l), .opn(lft_opn)
    );

    ir_opn_hyst #(.OPN_THRESH(OPN_THRESH), .HYST(HYST)) u_rght (
        .clk(clk), .rst_n(rst_n), .upd(state == UPDATE), .val(cor_r), .opn(rght_opn)
    );

endmodule
